// File: rtl/i2s_pkg.sv
// Shared I2S definitions used by both the transmitter and the receiver.
package i2s_pkg;
  localparam int DEFAULT_WIDTH = 16;

  function automatic int frame_len(input int width);
    return 2 * width;
  endfunction

  function automatic int cnt_bits(input int width);
    return $clog2(2 * width);
  endfunction
endpackage

// File: rtl/i2s_frame_ctr.sv
// Frame bit counter for I2S; also derives the next-cycle word select and the wrap strobe.
module i2s_frame_ctr
  import i2s_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                           sclk,
  input  logic                           rst,
  output logic [cnt_bits(WIDTH)-1:0]     bit_cnt,
  output logic                           ws_next,
  output logic                           wrap
);
  localparam int CW = cnt_bits(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(frame_len(WIDTH) - 1);

  logic [CW-1:0] bit_cnt_q, bit_cnt_d;

  // ws leads each channel's MSB by one bit, so it is 1 from the left LSB to the right bit before LSB.
  always_comb begin
    wrap      = (bit_cnt_q == LAST);
    bit_cnt_d = wrap ? '0 : bit_cnt_q + CW'(1);
    ws_next   = (bit_cnt_d >= CW'(WIDTH - 1)) && (bit_cnt_d != LAST);
  end

  always_ff @(negedge sclk) begin
    if (rst) bit_cnt_q <= LAST;
    else     bit_cnt_q <= bit_cnt_d;
  end

  assign bit_cnt = bit_cnt_q;
endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one-deep holding register, frame load at wrap, MSB-first serialiser.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic [WIDTH-1:0] left_in,
  input  logic [WIDTH-1:0] right_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ws,
  output logic             sdata,
  output logic             underrun
);
  localparam int CW = cnt_bits(WIDTH);

  logic [CW-1:0]    bit_cnt, bit_nxt, idx;
  logic             ws_next, wrap, accept;
  logic [WIDTH-1:0] sel_word, shifted;

  logic [WIDTH-1:0] hold_left_q, hold_left_d, hold_right_q, hold_right_d;
  logic [WIDTH-1:0] frame_left_q, frame_left_d, frame_right_q, frame_right_d;
  logic             hold_full_q, hold_full_d, started_q, started_d;
  logic             in_ready_q, in_ready_d, ws_q, ws_d;
  logic             sdata_q, sdata_d, underrun_q, underrun_d;

  i2s_frame_ctr #(.WIDTH(WIDTH)) u_frame_ctr (
    .sclk    (sclk),
    .rst     (rst),
    .bit_cnt (bit_cnt),
    .ws_next (ws_next),
    .wrap    (wrap)
  );

  always_comb begin
    accept        = in_valid & in_ready_q;
    hold_left_d   = hold_left_q;
    hold_right_d  = hold_right_q;
    hold_full_d   = hold_full_q;
    started_d     = started_q;
    frame_left_d  = frame_left_q;
    frame_right_d = frame_right_q;
    underrun_d    = 1'b0;

    if (wrap) begin
      frame_left_d  = hold_full_q ? hold_left_q  : '0;
      frame_right_d = hold_full_q ? hold_right_q : '0;
      hold_full_d   = 1'b0;
      underrun_d    = !hold_full_q && started_q;
    end
    // An accept on the wrap edge only fills holding; the frame just loaded stays as decided above.
    if (accept) begin
      hold_left_d  = left_in;
      hold_right_d = right_in;
      hold_full_d  = 1'b1;
      started_d    = 1'b1;
    end
    in_ready_d = !hold_full_d;

    bit_nxt = wrap ? '0 : bit_cnt + CW'(1);
    if (bit_nxt < CW'(WIDTH)) begin
      sel_word = frame_left_d;
      idx      = CW'(WIDTH - 1) - bit_nxt;
    end else begin
      sel_word = frame_right_d;
      idx      = CW'(2 * WIDTH - 1) - bit_nxt;
    end
    shifted = sel_word >> idx;
    sdata_d = shifted[0];
    ws_d    = ws_next;
  end

  always_ff @(negedge sclk) begin
    if (rst) begin
      hold_left_q   <= '0;
      hold_right_q  <= '0;
      hold_full_q   <= 1'b0;
      started_q     <= 1'b0;
      frame_left_q  <= '0;
      frame_right_q <= '0;
      in_ready_q    <= 1'b0;
      ws_q          <= 1'b0;
      sdata_q       <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      hold_left_q   <= hold_left_d;
      hold_right_q  <= hold_right_d;
      hold_full_q   <= hold_full_d;
      started_q     <= started_d;
      frame_left_q  <= frame_left_d;
      frame_right_q <= frame_right_d;
      in_ready_q    <= in_ready_d;
      ws_q          <= ws_d;
      sdata_q       <= sdata_d;
      underrun_q    <= underrun_d;
    end
  end

  assign in_ready = in_ready_q;
  assign ws       = ws_q;
  assign sdata    = sdata_q;
  assign underrun = underrun_q;
endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: frame-level reference model feeding a scoreboard, checked by an I2S receiver monitor.
module tb_i2s_tx;
  localparam int W  = 16;
  localparam int FL = 2 * W;

  logic          sclk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  left_in = '0;
  logic [W-1:0]  right_in = '0;
  logic          in_ready, ws, sdata, underrun;

  i2s_tx #(.WIDTH(W)) dut (
    .sclk     (sclk),
    .rst      (rst),
    .left_in  (left_in),
    .right_in (right_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ws       (ws),
    .sdata    (sdata),
    .underrun (underrun)
  );

  always #5 sclk = ~sclk;

  int tests = 0;
  int fails = 0;

  // Reference model state: frame phase, pending pairs, expected frames, per-cycle flags.
  int            phase = FL - 1;
  logic [2*W-1:0] pending[$];
  logic [2*W-1:0] exp_q[$];
  bit            started = 1'b0;
  bit            m_ready = 1'b0;
  bit            m_underrun = 1'b0;
  int            n_acc = 0;
  bit            mon_en = 1'b0;

  // Receiver state
  logic          prev_ws = 1'b0;
  logic [2*W-1:0] sr = '0;
  int            nbits = 0;
  logic [W-1:0]  rx_left = '0;
  int            rx_frames = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit v, input logic [W-1:0] l, input logic [W-1:0] rr);
    bit acc;
    @(posedge sclk);
    #2;
    rst      = r;
    in_valid = v;
    left_in  = l;
    right_in = rr;
    @(negedge sclk);
    if (r) begin
      phase      = FL - 1;
      pending.delete();
      exp_q.delete();
      started    = 1'b0;
      m_ready    = 1'b0;
      m_underrun = 1'b0;
    end else begin
      acc        = v && m_ready;
      phase      = (phase + 1) % FL;
      m_underrun = 1'b0;
      if (phase == 0) begin
        if (pending.size() > 0) exp_q.push_back(pending.pop_front());
        else begin
          exp_q.push_back('0);
          m_underrun = started;
        end
      end
      if (acc) begin
        pending.push_back({l, rr});
        started = 1'b1;
        n_acc++;
      end
      m_ready = (pending.size() == 0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, W'($urandom), W'($urandom));
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b0, ($urandom_range(0, 3) != 0), W'($urandom), W'($urandom));
  endtask

  // Monitor: handshake/underrun against the model each cycle, I2S deserialiser feeding the scoreboard.
  always @(posedge sclk) begin
    logic [2*W-1:0] e;
    if (mon_en) begin
      if (rst) begin
        chk("reset_outputs", {ws, sdata, underrun, in_ready}, 4'b0000);
        prev_ws = 1'b0;
        sr      = '0;
        nbits   = 0;
      end else begin
        chk("in_ready", in_ready, m_ready);
        chk("underrun", underrun, m_underrun);
        sr = {sr[2*W-2:0], sdata};
        nbits++;
        if (ws !== prev_ws) begin
          chk("word_len", nbits, W);
          if (prev_ws == 1'b0) rx_left = sr[W-1:0];
          else begin
            if (exp_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL frame_unexpected: got %0h expected none at %0t", {rx_left, sr[W-1:0]}, $time);
            end else begin
              e = exp_q.pop_front();
              chk("frame", {rx_left, sr[W-1:0]}, e);
            end
            rx_frames++;
          end
          nbits = 0;
        end
        prev_ws = ws;
      end
    end
  end

  initial begin
    int n0;
    int guard;
    cycle(1'b1, 1'b0, '0, '0);
    mon_en = 1'b1;
    cycle(1'b1, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, '0, '0);

    // No pair ever supplied: silent zero frames, no underrun.
    idle(80);

    // Directed pair, then starvation: pair frame followed by one underrun frame.
    n0 = n_acc;
    guard = 0;
    while (n_acc == n0 && guard < 100) begin
      cycle(1'b0, 1'b1, 16'hA5C3, 16'h0F0F);
      guard++;
    end
    idle(80);

    // Accept exactly on the wrap edge with holding empty.
    guard = 0;
    while (phase != FL - 1 && guard < 100) begin
      idle(1);
      guard++;
    end
    cycle(1'b0, 1'b1, W'($urandom), W'($urandom));
    idle(80);

    random_run(3400);

    // Reset at bit_cnt = 20 with a pair held; it must not resurface.
    guard = 0;
    while (!(phase == 20 && pending.size() > 0) && guard < 200) begin
      cycle(1'b0, 1'b1, W'($urandom), W'($urandom));
      guard++;
    end
    cycle(1'b1, 1'b0, '0, '0);
    idle(80);

    random_run(3400);
    idle(70);

    chk("frames_seen", (rx_frames > 200), 1'b1);
    chk("exp_backlog", (exp_q.size() <= 1), 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 16, bits per channel sample (legal range 8..32).
REQ-002 SHALL have port sclk, input, 1, the I2S bit clock and the only clock; all state updates on the falling edge of sclk.
REQ-003 SHALL have port rst, input, 1, reset; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port left_in, input, WIDTH, left sample, two's complement.
REQ-005 SHALL have port right_in, input, WIDTH, right sample, two's complement.
REQ-006 SHALL have port in_valid, input, 1, left_in/right_in pair offered.
REQ-007 SHALL have port in_ready, output, 1, holding register empty; a pair is accepted on a falling edge where in_valid and in_ready are both 1.
REQ-008 SHALL have port ws, output, 1, I2S word select (0 = left, 1 = right).
REQ-009 SHALL have port sdata, output, 1, I2S serial data, MSB first.
REQ-010 SHALL have port underrun, output, 1, one-cycle pulse; frame started with no pair held.

Function
REQ-011 SHALL keep bit_cnt, 0..2*WIDTH-1, incrementing every falling edge and wrapping 2*WIDTH-1 -> 0.
REQ-012 SHALL drive sdata = frame_left[WIDTH-1-k] while bit_cnt = k < WIDTH.
REQ-013 SHALL drive sdata = frame_right[2*WIDTH-1-k] while bit_cnt = k >= WIDTH.
REQ-014 SHALL drive ws = 1 for bit_cnt in WIDTH-1..2*WIDTH-2 and 0 otherwise, so each ws change leads the channel MSB by one sclk (I2S one-bit delay).
REQ-015 SHALL register ws and sdata; both change only on falling edges.
REQ-016 SHALL copy the holding register into frame_left/frame_right on the edge where bit_cnt wraps to 0, then mark holding empty.
REQ-017 SHALL, if holding is empty at the wrap edge, transmit zeros for the whole frame, with underrun = 1 for that cycle only when the started flag is set.
REQ-018 SHALL set the started flag on the first accepted pair; it stays set until rst.
REQ-019 SHALL drive in_ready as a registered !hold_full.
REQ-020 SHALL, when a pair is accepted on the wrap edge while holding is empty, store it in holding for the next frame; the current frame is zeros plus underrun; no bypass.
REQ-021 SHALL, when holding is full at the wrap edge, load it and raise in_ready on the following cycle; no accept occurs on that edge.
REQ-022 SHALL ignore left_in/right_in whenever no accept occurs.
REQ-023 SHALL have throughput of one pair per 2*WIDTH sclk cycles; latency from accept to MSB on sdata is at most 2*WIDTH+1 cycles.

Reset
REQ-024 SHALL, while rst = 1 on a falling edge, force bit_cnt = 2*WIDTH-1, ws = 0, sdata = 0, underrun = 0, in_ready = 0, holding empty, started = 0, frame registers = 0.
REQ-025 SHALL raise in_ready on the first edge after rst deasserts; the first wrap occurs on that same edge.
REQ-026 SHALL, if rst is asserted mid-frame, abandon the frame and discard any held pair; no partial word resumes.

Structure
REQ-027 SHALL take the default WIDTH and the frame length function (2*WIDTH) from shared package i2s_pkg, which the I2S receiver also uses.
REQ-028 SHALL place bit_cnt and ws generation in sub-module i2s_frame_ctr (parameter WIDTH; outputs bit_cnt, ws_next, wrap).
REQ-029 SHALL keep the holding register, shift/select logic and handshake in i2s_tx.

Verification
REQ-030 SHALL cover: WIDTH=16, accept left 0xA5C3 / right 0x0F0F after reset -> next frame sdata 1010010111000011 with ws=0, then 0000111100001111 with ws=1; ws falls one cycle before the left MSB.
REQ-031 SHALL cover: in_valid held high continuously -> one accept per 32 cycles; in_ready low from accept until the wrap edge.
REQ-032 SHALL cover: no pair supplied after the first frame -> next frame all zeros, underrun = 1 for exactly one cycle at the wrap.
REQ-033 SHALL cover: no pair ever supplied after reset -> sdata = 0 and underrun never asserts.
REQ-034 SHALL cover: accept exactly on the wrap edge with holding empty -> zero frame plus underrun, then the pair appears in the following frame.
REQ-035 SHALL cover: rst asserted at bit_cnt = 20 -> ws = 0, sdata = 0 the next cycle; the held pair is discarded; loopback into the team's I2S receiver recovers left/right bit-exact over 100 random pairs.
